// File: rtl/reg_check_sequencer.sv
// reg_check_sequencer
//   On-board self-check for the pipelined processor. A start request lets the
//   processor run for a programmable number of cycles. The block then stalls
//   the pipeline and walks a small table of (register, expected value) entries,
//   reading each register through the regfile debug port. Mismatches are
//   counted with saturation and reported one at a time.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   start, run_cycles   begin a run; run_cycles sampled together with start
//   tbl_wr_*            table write port (ignored while busy)
//   rf_rd_ctrl/_data    regfile debug read address / combinational read data
//   cpu_hold            pipeline stall, high only while checking
//   busy, done, pass    run status
//   error_count         saturating mismatch count for the current run
//   fail_valid, fail_*  one-cycle pulse and details of the latest mismatch
module reg_check_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_CHECKS     = 8,
  parameter int CNT_WIDTH      = 16,
  parameter int IDX_WIDTH      = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [CNT_WIDTH-1:0]      run_cycles,
  input  logic                      tbl_wr_en,
  input  logic [IDX_WIDTH-1:0]      tbl_wr_idx,
  input  logic                      tbl_wr_valid,
  input  logic [REG_ADDR_WIDTH-1:0] tbl_wr_reg,
  input  logic [DATA_WIDTH-1:0]     tbl_wr_value,
  output logic [REG_ADDR_WIDTH-1:0] rf_rd_ctrl,
  input  logic [DATA_WIDTH-1:0]     rf_rd_data,
  output logic                      cpu_hold,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [CNT_WIDTH-1:0]      error_count,
  output logic                      fail_valid,
  output logic [REG_ADDR_WIDTH-1:0] fail_reg,
  output logic [DATA_WIDTH-1:0]     fail_expected,
  output logic [DATA_WIDTH-1:0]     fail_read
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CHECKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]      run_cycles_q, run_cycles_d;
  logic [IDX_WIDTH-1:0]      idx_q, idx_d;
  logic [CNT_WIDTH-1:0]      err_q, err_d;
  logic                      fail_valid_q, fail_valid_d;
  logic [REG_ADDR_WIDTH-1:0] fail_reg_q, fail_reg_d;
  logic [DATA_WIDTH-1:0]     fail_expected_q, fail_expected_d;
  logic [DATA_WIDTH-1:0]     fail_read_q, fail_read_d;
  logic [REG_ADDR_WIDTH-1:0] last_reg_q, last_reg_d;

  logic                      tbl_valid_q [NUM_CHECKS];
  logic                      tbl_valid_d [NUM_CHECKS];
  logic [REG_ADDR_WIDTH-1:0] tbl_reg_q   [NUM_CHECKS];
  logic [REG_ADDR_WIDTH-1:0] tbl_reg_d   [NUM_CHECKS];
  logic [DATA_WIDTH-1:0]     tbl_value_q [NUM_CHECKS];
  logic [DATA_WIDTH-1:0]     tbl_value_d [NUM_CHECKS];

  logic in_busy;
  logic entry_fail;

  assign in_busy = (state_q == RUN) || (state_q == CHECK);

  // An entry fails only if it is enabled; skipped slots still consume a cycle.
  assign entry_fail = tbl_valid_q[idx_q] && (rf_rd_data != tbl_value_q[idx_q]);

  // Next-state logic. The table is write-protected while a run is in flight
  // so the entries being checked cannot change underneath the walk.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    run_cycles_d    = run_cycles_q;
    idx_d           = idx_q;
    err_d           = err_q;
    fail_valid_d    = 1'b0;
    fail_reg_d      = fail_reg_q;
    fail_expected_d = fail_expected_q;
    fail_read_d     = fail_read_q;
    last_reg_d      = last_reg_q;
    tbl_valid_d     = tbl_valid_q;
    tbl_reg_d       = tbl_reg_q;
    tbl_value_d     = tbl_value_q;

    if (tbl_wr_en && !in_busy) begin
      tbl_valid_d[tbl_wr_idx] = tbl_wr_valid;
      tbl_reg_d[tbl_wr_idx]   = tbl_wr_reg;
      tbl_value_d[tbl_wr_idx] = tbl_wr_value;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          run_cycles_d    = run_cycles;
          cnt_d           = '0;
          err_d           = '0;
          fail_reg_d      = '0;
          fail_expected_d = '0;
          fail_read_d     = '0;
          idx_d           = '0;
          state_d         = (run_cycles == '0) ? CHECK : RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (cnt_q == (run_cycles_q - CNT_WIDTH'(1))) begin
          idx_d   = '0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        last_reg_d = tbl_reg_q[idx_q];
        if (entry_fail) begin
          if (err_q != '1) begin
            err_d = err_q + CNT_WIDTH'(1);
          end
          fail_valid_d    = 1'b1;
          fail_reg_d      = tbl_reg_q[idx_q];
          fail_expected_d = tbl_value_q[idx_q];
          fail_read_d     = rf_rd_data;
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and table registers; reset empties the table so a stale table can
  // never produce checks after a board reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      run_cycles_q    <= '0;
      idx_q           <= '0;
      err_q           <= '0;
      fail_valid_q    <= 1'b0;
      fail_reg_q      <= '0;
      fail_expected_q <= '0;
      fail_read_q     <= '0;
      last_reg_q      <= '0;
      for (int i = 0; i < NUM_CHECKS; i++) begin
        tbl_valid_q[i] <= 1'b0;
        tbl_reg_q[i]   <= '0;
        tbl_value_q[i] <= '0;
      end
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      run_cycles_q    <= run_cycles_d;
      idx_q           <= idx_d;
      err_q           <= err_d;
      fail_valid_q    <= fail_valid_d;
      fail_reg_q      <= fail_reg_d;
      fail_expected_q <= fail_expected_d;
      fail_read_q     <= fail_read_d;
      last_reg_q      <= last_reg_d;
      tbl_valid_q     <= tbl_valid_d;
      tbl_reg_q       <= tbl_reg_d;
      tbl_value_q     <= tbl_value_d;
    end
  end

  // Outside CHECK the read address parks on the last register checked.
  assign rf_rd_ctrl    = (state_q == CHECK) ? tbl_reg_q[idx_q] : last_reg_q;
  assign cpu_hold      = (state_q == CHECK);
  assign busy          = in_busy;
  assign done          = (state_q == DONE);
  assign pass          = (state_q == DONE) && (err_q == '0);
  assign error_count   = err_q;
  assign fail_valid    = fail_valid_q;
  assign fail_reg      = fail_reg_q;
  assign fail_expected = fail_expected_q;
  assign fail_read     = fail_read_q;

endmodule

// File: tb/tb_reg_check_sequencer.sv
// tb_reg_check_sequencer
//   Directed bench for reg_check_sequencer. Stimulus tasks push expected
//   mismatch reports and run results into queues; a monitor on the falling
//   edge pops and compares them whenever the DUT reports something. A second
//   instance with a 2-bit counter exercises error_count saturation.
module tb_reg_check_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        start2;
  logic [15:0] run_cycles;
  logic        tbl_wr_en;
  logic [2:0]  tbl_wr_idx;
  logic        tbl_wr_valid;
  logic [4:0]  tbl_wr_reg;
  logic [31:0] tbl_wr_value;

  logic [4:0]  rf_rd_ctrl;
  logic [31:0] rf_rd_data;
  logic        cpu_hold, busy, done, pass, fail_valid;
  logic [15:0] error_count;
  logic [4:0]  fail_reg;
  logic [31:0] fail_expected, fail_read;

  logic [4:0]  rf_rd_ctrl2;
  logic [31:0] rf_rd_data2;
  logic        cpu_hold2, busy2, done2, pass2, fail_valid2;
  logic [1:0]  error_count2;
  logic [4:0]  fail_reg2;
  logic [31:0] fail_expected2, fail_read2;

  logic [31:0] rf [32];

  assign rf_rd_data  = rf[rf_rd_ctrl];
  assign rf_rd_data2 = rf[rf_rd_ctrl2];

  typedef struct {
    logic [4:0]  r;
    logic [31:0] e;
    logic [31:0] v;
  } fail_t;

  typedef struct {
    logic        p;
    logic [15:0] err;
    int          lat;
  } done_t;

  fail_t fail_q[$];
  done_t done_q[$];
  fail_t mon_f;
  done_t mon_d;

  int   tests_run = 0;
  int   fails = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   hold_cnt = 0;
  int   fail2_cnt = 0;
  logic done_prev = 1'b0;

  reg_check_sequencer #(
    .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .NUM_CHECKS(8), .CNT_WIDTH(16)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .run_cycles(run_cycles),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_idx(tbl_wr_idx), .tbl_wr_valid(tbl_wr_valid),
    .tbl_wr_reg(tbl_wr_reg), .tbl_wr_value(tbl_wr_value),
    .rf_rd_ctrl(rf_rd_ctrl), .rf_rd_data(rf_rd_data), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .pass(pass), .error_count(error_count),
    .fail_valid(fail_valid), .fail_reg(fail_reg),
    .fail_expected(fail_expected), .fail_read(fail_read)
  );

  reg_check_sequencer #(
    .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .NUM_CHECKS(8), .CNT_WIDTH(2)
  ) dut_sat (
    .clock(clock), .reset(reset), .start(start2), .run_cycles(run_cycles[1:0]),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_idx(tbl_wr_idx), .tbl_wr_valid(tbl_wr_valid),
    .tbl_wr_reg(tbl_wr_reg), .tbl_wr_value(tbl_wr_value),
    .rf_rd_ctrl(rf_rd_ctrl2), .rf_rd_data(rf_rd_data2), .cpu_hold(cpu_hold2),
    .busy(busy2), .done(done2), .pass(pass2), .error_count(error_count2),
    .fail_valid(fail_valid2), .fail_reg(fail_reg2),
    .fail_expected(fail_expected2), .fail_read(fail_read2)
  );

  // Free-running clock and an edge counter used to measure run latency.
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    tests_run++;
    fails++;
    $display("[TB] FAIL %s", name);
  endtask

  // Monitor: pops one expected mismatch per fail_valid pulse and one expected
  // result per rising edge of done. It also counts cpu_hold cycles per run.
  always @(negedge clock) begin
    if (reset) begin
      hold_cnt  = 0;
      done_prev = 1'b0;
    end else begin
      if (cpu_hold) hold_cnt++;
      if (fail_valid) begin
        if (fail_q.size() == 0) begin
          reportFail("unexpected_fail_valid");
        end else begin
          mon_f = fail_q.pop_front();
          checkOutput("fail_reg", 64'(fail_reg), 64'(mon_f.r));
          checkOutput("fail_expected", 64'(fail_expected), 64'(mon_f.e));
          checkOutput("fail_read", 64'(fail_read), 64'(mon_f.v));
        end
      end
      if (done && !done_prev) begin
        if (done_q.size() == 0) begin
          reportFail("unexpected_done");
        end else begin
          mon_d = done_q.pop_front();
          checkOutput("pass", 64'(pass), 64'(mon_d.p));
          checkOutput("error_count", 64'(error_count), 64'(mon_d.err));
          checkOutput("done_latency", 64'(cyc - start_cyc - 1), 64'(mon_d.lat));
          checkOutput("cpu_hold_cycles", 64'(hold_cnt), 64'd8);
          checkOutput("fail_reports_left", 64'(fail_q.size()), 64'd0);
        end
        hold_cnt = 0;
      end
      done_prev = done;
    end
  end

  // Counts mismatch pulses of the saturating instance.
  always @(negedge clock) begin
    if (reset) fail2_cnt = 0;
    else if (fail_valid2) fail2_cnt++;
  end

  task automatic writeEntry(input logic [2:0] idx, input logic vld,
                            input logic [4:0] r, input logic [31:0] val);
    @(negedge clock);
    tbl_wr_en    = 1'b1;
    tbl_wr_idx   = idx;
    tbl_wr_valid = vld;
    tbl_wr_reg   = r;
    tbl_wr_value = val;
    @(posedge clock);
    #1 tbl_wr_en = 1'b0;
  endtask

  task automatic startRun(input logic [15:0] rc, input logic also_sat);
    @(negedge clock);
    run_cycles = rc;
    start      = 1'b1;
    start2     = also_sat;
    start_cyc  = cyc;
    @(posedge clock);
    #1;
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!done) reportFail({name, "_timeout"});
    @(negedge clock);
  endtask

  task automatic applyStimulus(input logic [15:0] rc, input logic exp_pass,
                               input logic [15:0] exp_err, input logic also_sat);
    done_q.push_back('{exp_pass, exp_err, int'(rc) + 8});
    startRun(rc, also_sat);
    waitDone("run");
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_pass"}, 64'(pass), 64'd0);
    checkOutput({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd0);
    checkOutput({tag, "_error_count"}, 64'(error_count), 64'd0);
    checkOutput({tag, "_fail_valid"}, 64'(fail_valid), 64'd0);
    checkOutput({tag, "_fail_reg"}, 64'(fail_reg), 64'd0);
    checkOutput({tag, "_fail_expected"}, 64'(fail_expected), 64'd0);
    checkOutput({tag, "_fail_read"}, 64'(fail_read), 64'd0);
    checkOutput({tag, "_rf_rd_ctrl"}, 64'(rf_rd_ctrl), 64'd0);
  endtask

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Directed test sequence.
  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    start2       = 1'b0;
    run_cycles   = '0;
    tbl_wr_en    = 1'b0;
    tbl_wr_idx   = '0;
    tbl_wr_valid = 1'b0;
    tbl_wr_reg   = '0;
    tbl_wr_value = '0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;

    repeat (2) @(negedge clock);
    checkResetOutputs("reset");
    @(negedge clock);
    reset = 1'b0;

    // Three-entry table, all matching, 5 run cycles: done after 13 edges.
    rf[1] = 32'd3;
    rf[2] = 32'd2;
    rf[3] = 32'd5;
    writeEntry(3'd0, 1'b1, 5'd2, 32'd2);
    writeEntry(3'd1, 1'b1, 5'd1, 32'd3);
    writeEntry(3'd2, 1'b1, 5'd3, 32'd5);
    applyStimulus(16'd5, 1'b1, 16'd0, 1'b0);
    checkOutput("t1_rf_rd_ctrl_parked", 64'(rf_rd_ctrl), 64'd0);

    // Same table with r3 corrupted: one mismatch report.
    rf[3] = 32'd4;
    fail_q.push_back('{5'd3, 32'd5, 32'd4});
    applyStimulus(16'd5, 1'b0, 16'd1, 1'b0);
    checkOutput("t2_fail_reg_held", 64'(fail_reg), 64'd3);
    checkOutput("t2_fail_read_held", 64'(fail_read), 64'd4);

    // Full valid table, run_cycles = 0: straight into CHECK, done after 8.
    for (int i = 0; i < 8; i++) begin
      rf[8 + i] = 32'hA0 + 32'(i);
      writeEntry(3'(i), 1'b1, 5'(8 + i), 32'hA0 + 32'(i));
    end
    startRun(16'd0, 1'b0);
    checkOutput("t3_cpu_hold_next_cycle", 64'(cpu_hold), 64'd1);
    done_q.push_back('{1'b1, 16'd0, 8});
    waitDone("t3");

    // start and a table write during RUN are both ignored.
    done_q.push_back('{1'b1, 16'd0, 13});
    startRun(16'd5, 1'b0);
    repeat (2) @(negedge clock);
    start        = 1'b1;
    tbl_wr_en    = 1'b1;
    tbl_wr_idx   = 3'd0;
    tbl_wr_valid = 1'b1;
    tbl_wr_reg   = 5'd9;
    tbl_wr_value = 32'hDEAD_BEEF;
    @(posedge clock);
    #1;
    start     = 1'b0;
    tbl_wr_en = 1'b0;
    checkOutput("t4_still_busy", 64'(busy), 64'd1);
    waitDone("t4");
    applyStimulus(16'd0, 1'b1, 16'd0, 1'b0);

    // Reset during CHECK at idx 3, then a run with an empty table.
    startRun(16'd0, 1'b0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("t5_rf_rd_ctrl_idx3", 64'(rf_rd_ctrl), 64'd11);
    reset = 1'b1;
    #1;
    checkResetOutputs("t5_mid_reset");
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(16'd2, 1'b1, 16'd0, 1'b0);

    // Eight mismatching entries: 16-bit count reaches 8, 2-bit count sticks at 3.
    for (int i = 0; i < 8; i++) begin
      rf[16 + i] = 32'h200 + 32'(i);
      writeEntry(3'(i), 1'b1, 5'(16 + i), 32'h100 + 32'(i));
      fail_q.push_back('{5'(16 + i), 32'h100 + 32'(i), 32'h200 + 32'(i)});
    end
    applyStimulus(16'd2, 1'b0, 16'd8, 1'b1);
    checkOutput("t6_sat_done", 64'(done2), 64'd1);
    checkOutput("t6_sat_error_count", 64'(error_count2), 64'd3);
    checkOutput("t6_sat_fail_pulses", 64'(fail2_cnt), 64'd8);
    checkOutput("t6_sat_pass", 64'(pass2), 64'd0);
    checkOutput("t6_sat_fail_reg", 64'(fail_reg2), 64'd23);

    checkOutput("expected_results_left", 64'(done_q.size()), 64'd0);

    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
